// File: rtl/rv_int_pkg.sv
// rv_int_pkg: shared encodings for the RV32I integer execute slice.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: major opcodes, funct3 ALU op enum, debug code enum, EBREAK word.
package rv_int_pkg;

   // Major opcodes (instr[6:0]); the low two bits are part of the match,
   // so a word with instr[1:0] != 2'b11 never matches any of these.
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   // The only SYSTEM encoding this slice accepts.
   localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

   // funct3 doubles as the ALU operation select.
   typedef enum logic [2:0] {
      F3_ADD  = 3'b000,   // ADD/SUB/ADDI
      F3_SLL  = 3'b001,
      F3_SLT  = 3'b010,
      F3_SLTU = 3'b011,
      F3_XOR  = 3'b100,
      F3_SR   = 3'b101,   // SRL/SRA and immediate forms
      F3_OR   = 3'b110,
      F3_AND  = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      DBG_NONE    = 2'b00,
      DBG_BREAK   = 2'b01,
      DBG_ILLEGAL = 2'b10
   } dbg_e;

endpackage

// File: rtl/rv_regfile_32x32.sv
// rv_regfile_32x32: 32x32 register file, x0 hardwired to zero.
// Latency: reads combinational; write lands at the rising clk edge.
// Backpressure: none; a write with we high is always accepted.
// Ports: clk, rst (async, active-high, clears all entries), we/waddr/wdata
//        write port, ra1/rd1 and ra2/rd2 async read ports; with
//        RV_REG_DEBUG_PORT_EN defined, a third async read port ra3/rd3.
module rv_regfile_32x32 #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   localparam int IDXW = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [IDXW-1:0] waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [IDXW-1:0] ra1,
   output logic [XLEN-1:0] rd1,
   input  logic [IDXW-1:0] ra2,
   output logic [XLEN-1:0] rd2
`ifdef RV_REG_DEBUG_PORT_EN
   ,
   input  logic [IDXW-1:0] ra3,
   output logic [XLEN-1:0] rd3
`endif
);

   logic [XLEN-1:0] regs [NREGS];

   // Writes to x0 are dropped here so the caller can keep wb_en/wb_idx
   // faithful to the decoded instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
`ifdef RV_REG_DEBUG_PORT_EN
   assign rd3 = (ra3 == '0) ? '0 : regs[ra3];
`endif

endmodule

// File: rtl/rv_int_exec_core.sv
// rv_int_exec_core: single-issue RV32I integer execute slice (decode, regfile, ALU).
// Latency: result combinational from instr; written back at the next rising clk edge.
// Backpressure: none; one instruction is consumed every clock.
// Ports: clk, rst (async, active-high), instr in; wb_en/wb_idx/wb_data describe
//        the write performed at the next edge; debug = 00 normal, 01 EBREAK,
//        10 illegal. Optional macro RV_REG_DEBUG_PORT_EN adds dbg_idx in /
//        dbg_data out, a third async register read port.
module rv_int_exec_core
   import rv_int_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     instr,
   output logic            wb_en,
   output logic [4:0]      wb_idx,
   output logic [XLEN-1:0] wb_data,
   output logic [1:0]      debug
`ifdef RV_REG_DEBUG_PORT_EN
   ,
   input  logic [4:0]      dbg_idx,
   output logic [XLEN-1:0] dbg_data
`endif
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      rs1_idx;
   logic [4:0]      rs2_idx;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] op_b;
   logic [4:0]      shamt;
   logic            alt;        // SUB / arithmetic right shift
   logic            illegal;
   logic            is_break;
   logic [XLEN-1:0] alu_res;
   dbg_e            dbg;

   assign opcode  = instr[6:0];
   assign funct3  = instr[14:12];
   assign funct7  = instr[31:25];
   assign rs1_idx = instr[19:15];
   assign rs2_idx = instr[24:20];
   assign wb_idx  = instr[11:7];
   assign imm_i   = {{(XLEN-12){instr[31]}}, instr[31:20]};

   rv_regfile_32x32 #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
      .clk   (clk),
      .rst   (rst),
      .we    (wb_en),
      .waddr (wb_idx),
      .wdata (wb_data),
      .ra1   (rs1_idx),
      .rd1   (rs1_data),
      .ra2   (rs2_idx),
      .rd2   (rs2_data)
`ifdef RV_REG_DEBUG_PORT_EN
      ,
      .ra3   (dbg_idx),
      .rd3   (dbg_data)
`endif
   );

   // Decode: legality, operand B source and the instr[30] modifier.
   // instr[30] is only honoured where it selects SUB or SRA/SRAI; for
   // ADDI it is an ordinary immediate bit and must not flip to subtract.
   always_comb begin
      illegal  = 1'b0;
      is_break = 1'b0;
      alt      = 1'b0;
      op_b     = rs2_data;
      case (opcode)
         OP: begin
            if (funct7 == 7'b0000000) begin
               alt = 1'b0;
            end else if (funct7 == 7'b0100000 &&
                         (funct3 == F3_ADD || funct3 == F3_SR)) begin
               alt = 1'b1;
            end else begin
               illegal = 1'b1;
            end
         end
         OP_IMM: begin
            op_b = imm_i;
            if (funct3 == F3_SLL) begin
               illegal = (funct7 != 7'b0000000);
            end else if (funct3 == F3_SR) begin
               if (funct7 == 7'b0100000)      alt     = 1'b1;
               else if (funct7 != 7'b0000000) illegal = 1'b1;
            end
         end
         LUI: ;
         SYSTEM: begin
            if (instr == EBREAK_WORD) is_break = 1'b1;
            else                      illegal  = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

   assign shamt = op_b[4:0];

   always_comb begin
      alu_res = '0;
      case (alu_op_e'(funct3))
         F3_ADD:  alu_res = alt ? (rs1_data - op_b) : (rs1_data + op_b);
         F3_SLL:  alu_res = rs1_data << shamt;
         F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(op_b))};
         F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, (rs1_data < op_b)};
         F3_XOR:  alu_res = rs1_data ^ op_b;
         F3_SR:   alu_res = alt ? XLEN'($signed(rs1_data) >>> shamt) : (rs1_data >> shamt);
         F3_OR:   alu_res = rs1_data | op_b;
         F3_AND:  alu_res = rs1_data & op_b;
         default: alu_res = '0;
      endcase
   end

   assign wb_data = (opcode == LUI) ? {instr[31:12], 12'b0} : alu_res;

   assign dbg   = illegal ? DBG_ILLEGAL : (is_break ? DBG_BREAK : DBG_NONE);
   assign debug = dbg;
   assign wb_en = (dbg == DBG_NONE) && !rst;

endmodule

// File: tb/tb_rv_int_exec_core.sv
module tb_rv_int_exec_core;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        wb_en;
   logic [4:0]  wb_idx;
   logic [31:0] wb_data;
   logic [1:0]  debug;
`ifdef RV_REG_DEBUG_PORT_EN
   logic [4:0]  dbg_idx;
   logic [31:0] dbg_data;
`endif

   int total = 0;
   int bad   = 0;

   rv_int_exec_core dut (
      .clk     (clk),
      .rst     (rst),
      .instr   (instr),
      .wb_en   (wb_en),
      .wb_idx  (wb_idx),
      .wb_data (wb_data),
      .debug   (debug)
`ifdef RV_REG_DEBUG_PORT_EN
      ,
      .dbg_idx (dbg_idx),
      .dbg_data(dbg_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ADD x31, xr, x0: copies xr to wb_data so a register can be observed.
   function automatic logic [31:0] rd_reg(input int r);
      return 32'h0000_0FB3 | (32'(r) << 15);
   endfunction

   // Present an instruction mid-cycle; outputs are sampled 1 time unit later,
   // well away from the rising edge that commits it.
   task automatic issue(input logic [31:0] w);
      @(negedge clk);
      instr = w;
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      issue(32'h0050_0093);
      total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL rst_wb_en got=%b exp=0", wb_en); end
      total++; if (wb_data !== 32'd5) begin bad++; $display("FAIL rst_wb_data_tracks got=%h exp=%h", wb_data, 32'd5); end
      issue(rd_reg(1));
      total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL rst_x1_zero got=%h exp=0", wb_data); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_addi;
      issue(32'h0050_0093);   // ADDI x1,x0,5
      total++; if (wb_data !== 32'd5) begin bad++; $display("FAIL addi_x1 got=%h exp=%h", wb_data, 32'd5); end
      total++; if (wb_en !== 1'b1 || wb_idx !== 5'd1 || debug !== 2'b00) begin
         bad++; $display("FAIL addi_ctl got=%b/%0d/%b exp=1/1/00", wb_en, wb_idx, debug); end
      issue(32'hFFD0_0113);   // ADDI x2,x0,-3
      total++; if (wb_data !== 32'hFFFF_FFFD) begin bad++; $display("FAIL addi_x2 got=%h exp=FFFFFFFD", wb_data); end
      issue(rd_reg(1));
      total++; if (wb_data !== 32'd5) begin bad++; $display("FAIL read_x1 got=%h exp=5", wb_data); end
      issue(rd_reg(2));
      total++; if (wb_data !== 32'hFFFF_FFFD) begin bad++; $display("FAIL read_x2 got=%h exp=FFFFFFFD", wb_data); end
      issue(32'h4000_8413);   // ADDI x8,x1,0x400 (instr[30]=1, still an add)
      total++; if (wb_data !== 32'h0000_0405) begin bad++; $display("FAIL addi_bit30 got=%h exp=00000405", wb_data); end
   endtask

   task automatic test_alu;
      issue(32'h4020_81B3);   // SUB x3,x1,x2
      total++; if (wb_data !== 32'd8) begin bad++; $display("FAIL sub got=%h exp=8", wb_data); end
      issue(32'h0020_B2B3);   // SLTU x5,x1,x2
      total++; if (wb_data !== 32'd1) begin bad++; $display("FAIL sltu got=%h exp=1", wb_data); end
      issue(32'h0020_A2B3);   // SLT x5,x1,x2
      total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL slt got=%h exp=0", wb_data); end
      issue(32'hFFF0_B493);   // SLTIU x9,x1,-1
      total++; if (wb_data !== 32'd1) begin bad++; $display("FAIL sltiu got=%h exp=1", wb_data); end
      issue(32'h0010_9533);   // SLL x10,x1,x1
      total++; if (wb_data !== 32'h0000_00A0) begin bad++; $display("FAIL sll got=%h exp=000000A0", wb_data); end
      issue(32'h0020_C5B3);   // XOR x11,x1,x2
      total++; if (wb_data !== 32'hFFFF_FFF8) begin bad++; $display("FAIL xor got=%h exp=FFFFFFF8", wb_data); end
      issue(32'h0020_F633);   // AND x12,x1,x2
      total++; if (wb_data !== 32'd5) begin bad++; $display("FAIL and got=%h exp=5", wb_data); end
      issue(32'h0020_E633);   // OR x12,x1,x2
      total++; if (wb_data !== 32'hFFFF_FFFD) begin bad++; $display("FAIL or got=%h exp=FFFFFFFD", wb_data); end
      issue(rd_reg(3));
      total++; if (wb_data !== 32'd8) begin bad++; $display("FAIL read_x3 got=%h exp=8", wb_data); end
   endtask

   task automatic test_shift_lui;
      issue(32'h4011_5213);   // SRAI x4,x2,1
      total++; if (wb_data !== 32'hFFFF_FFFE) begin bad++; $display("FAIL srai got=%h exp=FFFFFFFE", wb_data); end
      issue(32'h0011_5213);   // SRLI x4,x2,1
      total++; if (wb_data !== 32'h7FFF_FFFE) begin bad++; $display("FAIL srli got=%h exp=7FFFFFFE", wb_data); end
      issue(32'h1234_5337);   // LUI x6,0x12345
      total++; if (wb_data !== 32'h1234_5000 || wb_idx !== 5'd6) begin
         bad++; $display("FAIL lui got=%h/%0d exp=12345000/6", wb_data, wb_idx); end
      issue(rd_reg(6));
      total++; if (wb_data !== 32'h1234_5000) begin bad++; $display("FAIL read_x6 got=%h exp=12345000", wb_data); end
   endtask

   task automatic test_x0;
      issue(32'h0070_0013);   // ADDI x0,x0,7
      total++; if (wb_en !== 1'b1 || wb_idx !== 5'd0 || wb_data !== 32'd7) begin
         bad++; $display("FAIL x0_write_decode got=%b/%0d/%h exp=1/0/7", wb_en, wb_idx, wb_data); end
      issue(32'h0000_03B3);   // ADD x7,x0,x0
      total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL x0_reads_zero got=%h exp=0", wb_data); end
   endtask

   task automatic test_debug;
      issue(32'h0010_0073);   // EBREAK
      total++; if (debug !== 2'b01 || wb_en !== 1'b0) begin
         bad++; $display("FAIL ebreak got=%b/%b exp=01/0", debug, wb_en); end
      issue(32'h0000_0000);
      total++; if (debug !== 2'b10 || wb_en !== 1'b0) begin
         bad++; $display("FAIL zero_word got=%b/%b exp=10/0", debug, wb_en); end
      issue(32'h0220_81B3);   // OP funct7=0000001, rd=x3
      total++; if (debug !== 2'b10 || wb_en !== 1'b0) begin
         bad++; $display("FAIL bad_funct7 got=%b/%b exp=10/0", debug, wb_en); end
      issue(32'h4020_C5B3);   // OP funct7=0100000 with XOR
      total++; if (debug !== 2'b10) begin bad++; $display("FAIL alt_xor got=%b exp=10", debug); end
      issue(32'h0200_9513);   // SLLI with imm[11:5]=0000001, rd=x10
      total++; if (debug !== 2'b10) begin bad++; $display("FAIL slli_imm got=%b exp=10", debug); end
      issue(32'h0000_0073);   // ECALL
      total++; if (debug !== 2'b10) begin bad++; $display("FAIL ecall got=%b exp=10", debug); end
      issue(32'h0050_0092);   // ADDI with instr[1:0]=10
      total++; if (debug !== 2'b10) begin bad++; $display("FAIL low_bits got=%b exp=10", debug); end
      issue(rd_reg(3));
      total++; if (wb_data !== 32'd8) begin bad++; $display("FAIL x3_kept got=%h exp=8", wb_data); end
      issue(rd_reg(10));
      total++; if (wb_data !== 32'h0000_00A0) begin bad++; $display("FAIL x10_kept got=%h exp=000000A0", wb_data); end
   endtask

   task automatic test_reset_mid;
      issue(rd_reg(1));
      total++; if (wb_data !== 32'd5) begin bad++; $display("FAIL pre_rst_x1 got=%h exp=5", wb_data); end
      @(negedge clk);
      rst   = 1'b1;
      instr = 32'h0090_0693;  // ADDI x13,x0,9, held across an edge in reset
      #1;
      total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL mid_rst_wb_en got=%b exp=0", wb_en); end
      issue(rd_reg(1));
      total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL mid_rst_x1 got=%h exp=0", wb_data); end
      issue(32'h0090_0693);
      @(negedge clk);
      rst   = 1'b0;
      instr = 32'h0030_0713;  // ADDI x14,x0,3 on the first edge after release
      #1;
      total++; if (wb_en !== 1'b1) begin bad++; $display("FAIL post_rst_wb_en got=%b exp=1", wb_en); end
      issue(rd_reg(14));
      total++; if (wb_data !== 32'd3) begin bad++; $display("FAIL post_rst_x14 got=%h exp=3", wb_data); end
      issue(rd_reg(13));
      total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL rst_no_write_x13 got=%h exp=0", wb_data); end
   endtask

   initial begin
      rst   = 1'b0;
      instr = 32'h0000_0013;
`ifdef RV_REG_DEBUG_PORT_EN
      dbg_idx = 5'd0;
`endif
      test_reset();
      test_addi();
      test_alu();
      test_shift_lui();
      test_x0();
      test_debug();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rv_int_exec_core.md
Name: rv_int_exec_core

Overview:
- Single-issue RV32I integer execute slice: decoder, 32x32 general-purpose register file and ALU.
- Consumes one 32-bit instruction per clock and writes back the result at the clock edge.
- Flags breakpoint and illegal-instruction conditions to the surrounding test/control logic.
- Fetch and program counter are external; no memory access or branch support.

Parameters:
- XLEN, 32, datapath and register width (only 32 supported).
- NREGS, 32, architectural register count (index width 5).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high; clears register file
- instr  in  32  instruction to execute this cycle, held stable from edge to edge
- wb_en  out  1  register write occurs at next rising edge
- wb_idx  out  5  destination register (rd)
- wb_data  out  32  ALU result
- debug  out  2  00 normal, 01 EBREAK, 10 illegal instruction, 11 never driven

Behaviour:
- Decode, register read and ALU are combinational from instr and register state; write happens at the rising edge. Result is visible on reads one cycle later; no bypass needed.
- Supported instructions:
  - OP (0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - LUI (0110111).
  - EBREAK, exact word 0x00100073.
- ALU op select = funct3. Modifier = instr[30], valid only for SUB (OP, funct3 000) and SRA/SRAI (funct3 101).
- I-immediate = sign-extended instr[31:20]. Shift amount = operand B [4:0]. LUI result = {instr[31:12], 12'b0}.
- SLT/SLTI compare signed; SLTU/SLTIU compare unsigned, with the immediate sign-extended first. Result is 1 or 0. Add/sub wrap modulo 2^32.
- Illegal (debug = 10) when any of:
  - instr[1:0] != 11.
  - Unlisted opcode.
  - OP funct7 is not 0000000, or is 0100000 with funct3 other than 000/101.
  - SLLI/SRLI with imm[11:5] != 0; SRAI with imm[11:5] != 0100000.
  - SYSTEM opcode other than the exact EBREAK word.
- wb_en = 1 only when debug = 00 and rst = 0. EBREAK and illegal instructions never write.
- x0 always reads 0; writes to x0 are discarded, while wb_en/wb_idx still reflect the decode.
- Register file: two asynchronous read ports (rs1 = instr[19:15], rs2 = instr[24:20]), one synchronous write port.
- Reset: all registers 0 asynchronously; while rst is high no write occurs. Outputs stay combinational (wb_data/debug track instr); wb_en = 0.
- Reset deasserted mid-stream: the first edge after deassertion performs a normal write.
- Same register as source and destination: the old value is used and the new value is written at the edge.
- debug is combinational and changes only with instr.

Optional Feature:
- Macro RV_REG_DEBUG_PORT_EN.
- Defined: adds input dbg_idx[4:0] and output dbg_data[31:0], a third asynchronous read port of the register file (x0 reads 0).
- Undefined: the ports are absent and behaviour is otherwise identical.

Decomposition:
- Package rv_int_pkg holds:
  - opcode constants (OP, OP_IMM, LUI, SYSTEM);
  - funct3 ALU op enum;
  - debug code enum (DBG_NONE, DBG_BREAK, DBG_ILLEGAL);
  - the EBREAK encoding constant.
- Sub-module rv_regfile_32x32: async read ports, sync write, x0 hardwiring, async reset clear.
- Decoder and ALU stay in the top module.

Test Plan:
- After rst pulse, ADDI x1,x0,5 (0x00500093) then ADDI x2,x0,-3 (0xFFD00113): wb_data 5 then 0xFFFFFFFD; later reads match.
- SUB x3,x1,x2 (0x402081B3) -> wb_data 8. SLTU x5,x1,x2 (0x0020B2B3) -> 1. SLT equivalent (funct3 010, 0x0020A2B3) -> 0.
- SRAI x4,x2,1 (0x40115213) -> 0xFFFFFFFE. SRLI same operand (0x00115213) -> 0x7FFFFFFE. LUI x6,0x12345 (0x12345337) -> 0x12345000.
- ADDI x0,x0,7 (0x00700013), then ADD x7,x0,x0 -> 0; x0 unchanged.
- EBREAK 0x00100073 -> debug 01, wb_en 0. Word 0x00000000 and OP funct7 0000001 (0x022081B3) -> debug 10, no register changes.
- Assert rst mid-sequence with x1 = 5 -> x1 reads 0 immediately, no write during reset; the instruction on the first edge after release is written.
